// File: rtl/colparity_pkg.sv
// Shared definitions for the column-parity page sequencer.
//   state_t : sequencer FSM states
//   WIDTH   : page width in bits (5 rows x 5 columns)
//   COLS    : number of columns stepped per page
//   RES_W   : width of the per-page column-parity result
package colparity_pkg;

    localparam int WIDTH = 25;
    localparam int COLS  = 5;
    localparam int RES_W = 5;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RD_PREV   = 3'd1,
        S_WAIT_PREV = 3'd2,
        S_RD_CUR    = 3'd3,
        S_WAIT_CUR  = 3'd4,
        S_RUN       = 3'd5,
        S_WRITE     = 3'd6,
        S_DONE      = 3'd7
    } state_t;

endpackage

// File: rtl/colparity_page_counter.sv
// Page counter for the column-parity sequencer.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-low reset
//   clr   : synchronous clear to page 0 (takes priority over inc)
//   inc   : advance to the next page
//   page  : current page number
//   last  : high while page == PAGES-1
module colparity_page_counter #(
    parameter int PAGES = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [AW-1:0] page,
    output logic          last
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            page <= '0;
        end else if (clr) begin
            page <= '0;
        end else if (inc) begin
            page <= page + AW'(1);
        end
    end

    assign last = (page == AW'(PAGES - 1));

endmodule

// File: rtl/colparity_page_ctrl.sv
// Sequencer driving the 25-bit column-parity datapath over PAGES pages.
// For page p it loads the predecessor page (page PAGES-1 for p=0) and the
// current page, steps the datapath through column indices 0..4 and writes
// the 5-bit result dp_parity2_out[24:20] to the result store at address p.
//
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   start             : run request, only sampled in IDLE
//   busy, done        : run in progress / one-cycle completion pulse
//   mem_rd_en/addr    : page-store read port, data returns 1 cycle later
//   mem_rd_data       : page-store read data
//   dp_rst            : registered active-high datapath reset
//   dp_index          : column index for the datapath
//   dp_curr_parity    : current-page register
//   dp_prev_page      : previous-page register
//   dp_parity2_out    : datapath result register
//   res_wr_en/addr    : result-store write strobe and page address
//   res_wr_data       : 5-bit column-parity result
//   state_dbg         : current FSM state (colparity_pkg::state_t encoding)
//
// Handshake: there is no back-pressure. mem_rd_data is taken exactly one
// cycle after mem_rd_en; res_wr_en is a single-cycle write that the result
// store must accept unconditionally.
module colparity_page_ctrl #(
    parameter int PAGES = 64,
    parameter int AW    = $clog2(PAGES),
    parameter int WIDTH = colparity_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             mem_rd_en,
    output logic [AW-1:0]    mem_addr,
    input  logic [WIDTH-1:0] mem_rd_data,
    output logic             dp_rst,
    output logic [4:0]       dp_index,
    output logic [WIDTH-1:0] dp_curr_parity,
    output logic [WIDTH-1:0] dp_prev_page,
    input  logic [WIDTH-1:0] dp_parity2_out,
    output logic             res_wr_en,
    output logic [AW-1:0]    res_addr,
    output logic [4:0]       res_wr_data,
    output logic [2:0]       state_dbg
);

    import colparity_pkg::*;

    state_t           state;
    logic [2:0]       idx;
    logic [WIDTH-1:0] prev_reg;
    logic [WIDTH-1:0] cur_reg;
    logic [AW-1:0]    page;
    logic             last_page;
    logic             pc_clr;
    logic             pc_inc;
    logic             unused_dp_low;

    assign pc_clr = (state == S_IDLE) && start;
    assign pc_inc = (state == S_WRITE) && !last_page;

    colparity_page_counter #(
        .PAGES(PAGES),
        .AW   (AW)
    ) u_page_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (pc_clr),
        .inc  (pc_inc),
        .page (page),
        .last (last_page)
    );

    // Strobes and addresses are registered against the state being entered,
    // so they are valid for the whole cycle spent in that state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            prev_reg  <= '0;
            cur_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            res_wr_en <= 1'b0;
            res_addr  <= '0;
            dp_index  <= '0;
            dp_rst    <= 1'b1;
        end else begin
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            res_wr_en <= 1'b0;
            res_addr  <= '0;
            done      <= 1'b0;
            dp_index  <= '0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_RD_PREV;
                        busy      <= 1'b1;
                        dp_rst    <= 1'b0;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= AW'(PAGES - 1);
                    end else begin
                        busy   <= 1'b0;
                        dp_rst <= 1'b1;
                    end
                end
                S_RD_PREV: begin
                    state <= S_WAIT_PREV;
                end
                S_WAIT_PREV: begin
                    prev_reg  <= mem_rd_data;
                    state     <= S_RD_CUR;
                    mem_rd_en <= 1'b1;
                    mem_addr  <= page;
                end
                S_RD_CUR: begin
                    state <= S_WAIT_CUR;
                end
                S_WAIT_CUR: begin
                    cur_reg <= mem_rd_data;
                    idx     <= '0;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    if (idx == 3'(COLS - 1)) begin
                        idx       <= '0;
                        state     <= S_WRITE;
                        res_wr_en <= 1'b1;
                        res_addr  <= page;
                    end else begin
                        idx      <= idx + 3'd1;
                        dp_index <= {2'b00, idx + 3'd1};
                    end
                end
                S_WRITE: begin
                    // The current page becomes the predecessor of the next one.
                    prev_reg <= cur_reg;
                    if (last_page) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        // The counter advances on this same edge.
                        state     <= S_RD_CUR;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= page + AW'(1);
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    dp_rst <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // The datapath result register already holds the idx=4 update in WRITE,
    // so the write data is taken straight from it during the strobe cycle.
    assign res_wr_data    = res_wr_en ? dp_parity2_out[WIDTH-1 -: RES_W] : '0;
    assign dp_curr_parity = cur_reg;
    assign dp_prev_page   = prev_reg;
    assign state_dbg      = state;
    assign unused_dp_low  = ^dp_parity2_out[WIDTH-RES_W-1:0];

endmodule

// File: tb/tb_colparity_page_ctrl.sv
module tb_colparity_page_ctrl;

    localparam int WIDTH = 25;
    localparam int PA    = 4;
    localparam int AWA   = 2;
    localparam int PB    = 64;
    localparam int AWB   = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int total = 0;
    int bad   = 0;

    // ---------------- instance A (4 pages) ----------------
    logic             a_start, a_busy, a_done, a_mem_rd_en, a_dp_rst, a_res_wr_en;
    logic [AWA-1:0]   a_mem_addr, a_res_addr;
    logic [WIDTH-1:0] a_mem_rd_data, a_curr, a_prev, a_p2;
    logic [4:0]       a_dp_index, a_res_wr_data;
    logic [2:0]       a_state;
    logic [WIDTH-1:0] a_mem [PA];

    colparity_page_ctrl #(.PAGES(PA), .AW(AWA), .WIDTH(WIDTH)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .mem_rd_en(a_mem_rd_en), .mem_addr(a_mem_addr), .mem_rd_data(a_mem_rd_data),
        .dp_rst(a_dp_rst), .dp_index(a_dp_index), .dp_curr_parity(a_curr),
        .dp_prev_page(a_prev), .dp_parity2_out(a_p2), .res_wr_en(a_res_wr_en),
        .res_addr(a_res_addr), .res_wr_data(a_res_wr_data), .state_dbg(a_state)
    );

    // ---------------- instance B (64 pages) ----------------
    logic             b_start, b_busy, b_done, b_mem_rd_en, b_dp_rst, b_res_wr_en;
    logic [AWB-1:0]   b_mem_addr, b_res_addr;
    logic [WIDTH-1:0] b_mem_rd_data, b_curr, b_prev, b_p2;
    logic [4:0]       b_dp_index, b_res_wr_data;
    logic [2:0]       b_state;
    logic [WIDTH-1:0] b_mem [PB];

    colparity_page_ctrl #(.PAGES(PB), .AW(AWB), .WIDTH(WIDTH)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .mem_rd_en(b_mem_rd_en), .mem_addr(b_mem_addr), .mem_rd_data(b_mem_rd_data),
        .dp_rst(b_dp_rst), .dp_index(b_dp_index), .dp_curr_parity(b_curr),
        .dp_prev_page(b_prev), .dp_parity2_out(b_p2), .res_wr_en(b_res_wr_en),
        .res_addr(b_res_addr), .res_wr_data(b_res_wr_data), .state_dbg(b_state)
    );

    // ---------------- reference functions ----------------
    // Page bit 5*row+col; a column is the 5 bits sharing the same col.
    function automatic logic col_par(input logic [WIDTH-1:0] pg, input int c);
        logic r;
        r = 1'b0;
        for (int row = 0; row < 5; row++) r = r ^ pg[5*row + c];
        return r;
    endfunction

    function automatic logic [4:0] page_result(input logic [WIDTH-1:0] prv, input logic [WIDTH-1:0] cur);
        logic [4:0] r;
        for (int c = 0; c < 5; c++) r[c] = col_par(cur, c) ^ col_par(prv, (c + 4) % 5);
        return r;
    endfunction

    // ---------------- page stores and datapath models ----------------
    always @(posedge clk) if (a_mem_rd_en) a_mem_rd_data <= a_mem[a_mem_addr];
    always @(posedge clk) if (b_mem_rd_en) b_mem_rd_data <= b_mem[b_mem_addr];

    always @(posedge clk) begin
        if (a_dp_rst) a_p2 <= '0;
        else if (a_dp_index < 5)
            a_p2[20 + int'(a_dp_index)] <= col_par(a_curr, int'(a_dp_index)) ^ col_par(a_prev, (int'(a_dp_index) + 4) % 5);
    end

    always @(posedge clk) begin
        if (b_dp_rst) b_p2 <= '0;
        else if (b_dp_index < 5)
            b_p2[20 + int'(b_dp_index)] <= col_par(b_curr, int'(b_dp_index)) ^ col_par(b_prev, (int'(b_dp_index) + 4) % 5);
    end

    // ---------------- scoreboard ----------------
    int         wr_cyc[$];
    logic [5:0] wr_addr[$];
    logic [4:0] wr_data[$];
    logic [5:0] rd_addr[$];
    logic [4:0] exp_q[$];
    int done_cyc, done_cnt, busy_first, busy_last, busy_cnt, post_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) b_start = v;
        else     a_start = v;
    endtask

    task automatic sample(input bit sel, input int k);
        logic bz, dn, re, we;
        logic [5:0] ra, wa;
        logic [4:0] wd;
        bz = sel ? b_busy : a_busy;
        dn = sel ? b_done : a_done;
        re = sel ? b_mem_rd_en : a_mem_rd_en;
        we = sel ? b_res_wr_en : a_res_wr_en;
        ra = sel ? b_mem_addr : {4'b0, a_mem_addr};
        wa = sel ? b_res_addr : {4'b0, a_res_addr};
        wd = sel ? b_res_wr_data : a_res_wr_data;
        if (bz) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = k;
            busy_last = k;
        end
        if (re) rd_addr.push_back(ra);
        if (we) begin
            wr_cyc.push_back(k);
            wr_addr.push_back(wa);
            wr_data.push_back(wd);
        end
        if (dn) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = k;
        end
    endtask

    // mode 0: one-cycle start; 1: start held through DONE; 2: extra start pulse in DONE.
    // Cycle k is the cycle following edge k-1, edge 0 being the start sample.
    task automatic run(input bit sel, input int mode, input int max_cyc);
        logic bz, we;
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); rd_addr.delete();
        done_cyc = -1; done_cnt = 0; busy_first = -1; busy_last = -1; busy_cnt = 0; post_busy = 0;
        set_start(sel, 1'b1);
        @(posedge clk); #1;
        if (mode != 1) set_start(sel, 1'b0);
        for (int k = 1; k <= max_cyc; k++) begin
            sample(sel, k);
            if (done_cyc >= 0) begin
                if (mode == 2) set_start(sel, 1'b1);
                break;
            end
            @(posedge clk); #1;
        end
        check("run_done_seen", done_cyc >= 0, 1'b1);
        for (int j = 1; j <= 3; j++) begin
            @(posedge clk); #1;
            if (j == 1 && mode != 0) set_start(sel, 1'b0);
            bz = sel ? b_busy : a_busy;
            we = sel ? b_res_wr_en : a_res_wr_en;
            if (bz) post_busy++;
            if (we) post_busy++;
        end
    endtask

    task automatic check_run_a(input logic [19:0] exp);
        logic [5:0] rd_exp [5];
        rd_exp[0] = 6'd3; rd_exp[1] = 6'd0; rd_exp[2] = 6'd1; rd_exp[3] = 6'd2; rd_exp[4] = 6'd3;
        check("a_done_cycle", done_cyc, 35);
        check("a_done_count", done_cnt, 1);
        check("a_busy_first", busy_first, 1);
        check("a_busy_last", busy_last, 35);
        check("a_busy_count", busy_cnt, 35);
        check("a_idle_after_done", post_busy, 0);
        check("a_write_count", wr_cyc.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < wr_cyc.size()) begin
                check("a_write_cycle", wr_cyc[k], 10 + 8*k);
                check("a_write_addr", wr_addr[k], k);
                check("a_write_data", wr_data[k], exp[5*k +: 5]);
            end
        end
        check("a_read_count", rd_addr.size(), 5);
        for (int k = 0; k < 5; k++)
            if (k < rd_addr.size()) check("a_read_addr", rd_addr[k], rd_exp[k]);
    endtask

    task automatic load_a(input logic [99:0] pages);
        for (int k = 0; k < PA; k++) a_mem[k] = pages[25*k +: 25];
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [99:0] pages;   // {page3, page2, page1, page0}
        logic [19:0] exp;     // {res3, res2, res1, res0}
    } vec_t;
    vec_t vt[5];

    initial begin
        // Hand-computed: res[c] = par(cur col c) ^ par(prev col (c+4)%5).
        vt[0].pages = {25'h0, 25'h0, 25'h0, 25'h0};
        vt[0].exp   = {5'h00, 5'h00, 5'h00, 5'h00};
        vt[1].pages = {25'h1FFFFFF, 25'h0, 25'h0, 25'h0};
        vt[1].exp   = {5'h1F, 5'h00, 5'h00, 5'h1F};
        vt[2].pages = {25'h0, 25'h0, 25'h0, 25'h1};
        vt[2].exp   = {5'h00, 5'h00, 5'h02, 5'h01};
        vt[3].pages = {25'h0, 25'h20, 25'h4, 25'h0};
        vt[3].exp   = {5'h02, 5'h09, 5'h04, 5'h00};
        vt[4].pages = {25'h1F00000, 25'h0, 25'h0, 25'h3};
        vt[4].exp   = {5'h1F, 5'h00, 5'h06, 5'h1C};

        a_start = 1'b0;
        b_start = 1'b0;
        load_a('0);
        for (int k = 0; k < PB; k++) b_mem[k] = '0;

        // Reset values
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("rst_busy", a_busy, 1'b0);
        check("rst_done", a_done, 1'b0);
        check("rst_mem_rd_en", a_mem_rd_en, 1'b0);
        check("rst_res_wr_en", a_res_wr_en, 1'b0);
        check("rst_dp_index", a_dp_index, 5'd0);
        check("rst_mem_addr", a_mem_addr, 2'd0);
        check("rst_res_addr", a_res_addr, 2'd0);
        check("rst_res_wr_data", a_res_wr_data, 5'd0);
        check("rst_dp_rst", a_dp_rst, 1'b1);
        check("rst_state", a_state, 3'd0);
        check("rst_b_dp_rst", b_dp_rst, 1'b1);
        check("rst_b_busy", b_busy, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check("idle_dp_rst", a_dp_rst, 1'b1);

        // Table-driven runs on the 4-page instance
        for (int v = 0; v < 5; v++) begin
            load_a(vt[v].pages);
            run(1'b0, 0, 60);
            check_run_a(vt[v].exp);
        end

        // start held high for the whole run: exactly one run
        load_a(vt[1].pages);
        run(1'b0, 1, 60);
        check_run_a(vt[1].exp);

        // start pulsed in DONE is ignored, a later start runs normally
        load_a(vt[2].pages);
        run(1'b0, 2, 60);
        check_run_a(vt[2].exp);
        load_a(vt[3].pages);
        run(1'b0, 0, 60);
        check_run_a(vt[3].exp);

        // Reset in cycle 6 (inside RUN) aborts at once
        load_a(vt[4].pages);
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("abort_in_run", a_state, 3'd5);
        #1 rst = 1'b0;
        #1;
        check("abort_busy", a_busy, 1'b0);
        check("abort_done", a_done, 1'b0);
        check("abort_mem_rd_en", a_mem_rd_en, 1'b0);
        check("abort_res_wr_en", a_res_wr_en, 1'b0);
        check("abort_dp_index", a_dp_index, 5'd0);
        check("abort_mem_addr", a_mem_addr, 2'd0);
        check("abort_res_wr_data", a_res_wr_data, 5'd0);
        check("abort_dp_rst", a_dp_rst, 1'b1);
        check("abort_curr", a_curr, 25'd0);
        check("abort_prev", a_prev, 25'd0);
        check("abort_state", a_state, 3'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        post_busy = 0;
        for (int j = 0; j < 20; j++) begin
            @(posedge clk); #1;
            if (a_busy || a_res_wr_en) post_busy++;
        end
        check("abort_no_activity", post_busy, 0);
        run(1'b0, 0, 60);
        check_run_a(vt[4].exp);

        // 64 random pages against the reference model
        for (int k = 0; k < PB; k++) b_mem[k] = WIDTH'($urandom_range(32'h1FFFFFF, 0));
        exp_q.delete();
        for (int k = 0; k < PB; k++) exp_q.push_back(page_result(b_mem[(k + PB - 1) % PB], b_mem[k]));
        run(1'b1, 0, 600);
        check("b_done_cycle", done_cyc, 515);
        check("b_busy_count", busy_cnt, 515);
        check("b_idle_after_done", post_busy, 0);
        check("b_write_count", wr_cyc.size(), 64);
        check("b_read_count", rd_addr.size(), 65);
        for (int k = 0; k < PB; k++) begin
            if (k < wr_cyc.size() && exp_q.size() > 0) begin
                check("b_write_cycle", wr_cyc[k], 10 + 8*k);
                check("b_write_addr", wr_addr[k], k);
                check("b_write_data", wr_data[k], exp_q.pop_front());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/colparity_page_ctrl.md
# colparity_page_ctrl

Sequencer that drives the 25-bit column-parity datapath across a memory of PAGES pages. For each page it supplies the current page and its predecessor, wrapping so page 0 uses page PAGES-1. It steps the datapath through column indices 0..4 and writes the 5-bit column-parity result per page to a result memory. It sits between the page store, the parity datapath instance and the result store, at the level above the datapath.

## Interface
- PAGES, 64, number of pages processed per run (≥2)
- AW, 6, page address width, $clog2(PAGES)
- WIDTH, 25, page width (5×5), fixed

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- start  in  1  single-cycle request to begin a run; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE inclusive
- done  out  1  one-cycle pulse in DONE
- mem_rd_en  out  1  page-store read strobe
- mem_addr  out  AW  page-store address
- mem_rd_data  in  WIDTH  read data, valid exactly 1 cycle after mem_rd_en
- dp_rst  out  1  registered, active-high reset to datapath
- dp_index  out  5  column index to datapath
- dp_curr_parity  out  WIDTH  current-page register
- dp_prev_page  out  WIDTH  previous-page register
- dp_parity2_out  in  WIDTH  datapath result register
- res_wr_en  out  1  result write strobe
- res_addr  out  AW  result address = page number
- res_wr_data  out  5  dp_parity2_out[24:20]

## Operation
- FSM states: IDLE, RD_PREV, WAIT_PREV, RD_CUR, WAIT_CUR, RUN, WRITE, DONE.
- IDLE: all strobes 0. start=1 → RD_PREV; page counter p←0.
- RD_PREV: mem_rd_en=1, mem_addr=PAGES-1 → WAIT_PREV.
- WAIT_PREV: prev_reg←mem_rd_data → RD_CUR.
- RD_CUR: mem_rd_en=1, mem_addr=p → WAIT_CUR.
- WAIT_CUR: cur_reg←mem_rd_data; idx←0 → RUN.
- RUN: dp_index=idx; idx increments each cycle; after idx=4 → WRITE. Exactly 5 RUN cycles.
- WRITE: res_wr_en=1, res_addr=p, res_wr_data=dp_parity2_out[24:20]; prev_reg←cur_reg. If p==PAGES-1 → DONE, else p←p+1 and → RD_CUR.
- DONE: done=1 → IDLE.
- dp_rst is a flop: 1 under reset and while next state is IDLE; 0 otherwise. The datapath is therefore cleared before every run.
- p and idx are modular counters. No arithmetic exceeds AW or 3 bits. p never wraps mid-run.
- start outside IDLE is ignored, including start in DONE.
- dp_curr_parity and dp_prev_page hold their values outside RUN.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, p=0, idx=0, prev_reg=cur_reg=0. busy, done, mem_rd_en, res_wr_en and dp_index are 0. mem_addr, res_addr and res_wr_data are 0. dp_rst=1.
- rst asserted mid-run aborts immediately. No further writes occur. The next run needs a fresh start.
- Cycle count from the edge that samples start (edge 0): RD_PREV in cycle 1, WAIT_PREV in cycle 2. Page k occupies cycles 3+8k .. 10+8k, with WRITE in cycle 10+8k. done is high in cycle 3+8·PAGES; busy falls the following cycle.
- PAGES=64 gives done at cycle 515.
- A datapath bit written at the RUN idx=4 edge is visible in WRITE. There is zero extra settle.

## Structure
- Shared package colparity_pkg holds:
  - the state enum;
  - constants WIDTH=25, COLS=5, RES_W=5.
- One natural sub-module, colparity_page_counter: the AW-bit page counter with clear, increment and last-page flag.
- The datapath is instantiated beside this block, not inside it.

## Test plan
- Reset mid-RUN (rst low in cycle 6, PAGES=4) → all outputs at reset values within the same cycle. No res_wr_en afterwards. A following start runs to completion normally.
- PAGES=4, pages all zero, start → res_wr_en in cycles 10, 18, 26, 34 with addr 0..3 and data 5'b0. done in cycle 35; busy high cycles 1..35.
- PAGES=4, page3=25'h1FFFFFF, others 0 → page 0 result equals the datapath model with prev=all ones and cur=0; mem_addr sequence is 3,0,1,2,3.
- Column parity check: random pages compared against a bit-exact reference model of the datapath (prev-page wrap included) for all 64 pages.
- start held high for the entire run → exactly one run. start pulsed in DONE → ignored; a new run begins only after the next IDLE sample.
